pipe_hazard_ctrl: RTL and testbench

Pipeline control unit that reads the IF/ID, ID/EX, EX/MEM and MEM/WB buffer-register fields and drives the stall and flush controls back into those registers and the PC.
- Detects load-use hazards and taken-branch flushes.
- Runs a halt-drain state machine that empties the pipeline behind a Halt instruction.
- Keeps saturating performance counters.
- Sits beside the datapath, between the hazard sources and the pipeline-register write enables.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 29 ++
 rtl/pipe_hazard_ctrl_load_use.sv | 44 ++++
 rtl/pipe_hazard_ctrl.sv | 170 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/halt control slice.
// The forwarding unit will import this package too, so keep it free of
// anything specific to the stall/flush controller.
package Pipe_Ctrl_PKG;

    // Controller states; the encoding is exported on the state port.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_e;

    // RV32 opcodes that matter for deciding which source registers are read.
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    // Control bundle driven back into the PC and the pipeline registers.
    typedef struct packed {
        logic pc_stall;
        logic ifid_stall;
        logic ifid_flush;
        logic idex_flush;
    } pipe_ctrl_t;

endpackage

// File: rtl/pipe_hazard_ctrl_load_use.sv
// Load-use detector: flags when the instruction in ID reads a register that
// the load currently in EX has not yet produced. Purely combinational.
module load_use_detect
    import Pipe_Ctrl_PKG::*;
(
    input  logic [31:0] id_instr,
    input  logic        ex_memread,
    input  logic [4:0]  ex_rd,
    output logic        load_use
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use_rs1;
    logic       use_rs2;
    logic       unused_instr_bits;

    assign opcode = id_instr[6:0];
    assign rs1    = id_instr[19:15];
    assign rs2    = id_instr[24:20];

    // Only the opcode and the two source fields matter here.
    assign unused_instr_bits = ^{id_instr[31:25], id_instr[14:7]};

    // Decide which source fields are real reads rather than immediate bits.
    always_comb begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b0;
        if ((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL)) begin
            use_rs1 = 1'b0;
        end
        if ((opcode == OP_R) || (opcode == OP_S) || (opcode == OP_B)) begin
            use_rs2 = 1'b1;
        end
    end

    // x0 is never a real dependency, so a load into x0 cannot cause a stall.
    always_comb begin
        load_use = ex_memread && (ex_rd != 5'd0) &&
                   ((use_rs1 && (ex_rd == rs1)) || (use_rs2 && (ex_rd == rs2)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control unit: turns load-use hazards, taken branches and Halt
// into stall/flush controls, drains the pipe behind a Halt, and keeps
// saturating performance counters.
module pipe_hazard_ctrl
    import Pipe_Ctrl_PKG::*;
#(
    parameter int CNT_W     = 32,
    parameter int DRAIN_MAX = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      id_instr,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_halt,
    input  logic             branch_taken,
    input  logic [31:0]      wb_instr,
    input  logic             wb_halt,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             halted,
    output logic             drain_err,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int TIMER_W = (DRAIN_MAX > 1) ? $clog2(DRAIN_MAX) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(DRAIN_MAX - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    ctrl_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               halted_q, halted_d;
    logic               drain_err_q, drain_err_d;
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   ret_q, ret_d;
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [CNT_W-1:0]   flush_q, flush_d;

    pipe_ctrl_t ctrl;
    logic       load_use;
    logic       active;
    logic       count_stall;
    logic       count_flush;

    load_use_detect u_load_use (
        .id_instr   (id_instr),
        .ex_memread (ex_memread),
        .ex_rd      (ex_rd),
        .load_use   (load_use)
    );

    // Next-state and zero-latency control decode; branch beats load-use beats halt.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        halted_d    = halted_q;
        drain_err_d = drain_err_q;
        ctrl        = '0;
        active      = 1'b0;
        count_stall = 1'b0;
        count_flush = 1'b0;
        case (state_q)
            RUN: begin
                active  = 1'b1;
                timer_d = '0;
                if (branch_taken) begin
                    ctrl.ifid_flush = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    count_flush     = 1'b1;
                end else if (load_use) begin
                    ctrl.pc_stall   = 1'b1;
                    ctrl.ifid_stall = 1'b1;
                    ctrl.idex_flush = 1'b1;
                    count_stall     = 1'b1;
                end else if (ex_halt) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                active          = 1'b1;
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_stall = 1'b1;
                ctrl.idex_flush = 1'b1;
                timer_d         = timer_q + 1'b1;
                if (wb_halt) begin
                    state_d  = HALTED;
                    halted_d = 1'b1;
                end else if (timer_q == TIMER_LAST) begin
                    state_d     = HALTED;
                    halted_d    = 1'b1;
                    drain_err_d = 1'b1;
                end
            end
            HALTED: begin
                ctrl.pc_stall   = 1'b1;
                ctrl.ifid_stall = 1'b1;
                ctrl.idex_flush = 1'b1;
                halted_d        = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (!reset) begin
            ctrl = '0;
        end
    end

    // Saturating counter updates; nothing counts once the core is halted.
    always_comb begin
        cyc_d   = cyc_q;
        ret_d   = ret_q;
        stall_d = stall_q;
        flush_d = flush_q;
        if (active && (cyc_q != '1)) begin
            cyc_d = cyc_q + CNT_ONE;
        end
        if (active && (wb_instr != 32'd0) && (ret_q != '1)) begin
            ret_d = ret_q + CNT_ONE;
        end
        if (count_stall && (stall_q != '1)) begin
            stall_d = stall_q + CNT_ONE;
        end
        if (count_flush && (flush_q != '1)) begin
            flush_d = flush_q + CNT_ONE;
        end
    end

    // State, drain timer, status flags and counters; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RUN;
            timer_q     <= '0;
            halted_q    <= 1'b0;
            drain_err_q <= 1'b0;
            cyc_q       <= '0;
            ret_q       <= '0;
            stall_q     <= '0;
            flush_q     <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            halted_q    <= halted_d;
            drain_err_q <= drain_err_d;
            cyc_q       <= cyc_d;
            ret_q       <= ret_d;
            stall_q     <= stall_d;
            flush_q     <= flush_d;
        end
    end

    assign pc_stall   = ctrl.pc_stall;
    assign ifid_stall = ctrl.ifid_stall;
    assign ifid_flush = ctrl.ifid_flush;
    assign idex_flush = ctrl.idex_flush;
    assign halted     = halted_q;
    assign drain_err  = drain_err_q;
    assign state      = state_q;
    assign cyc_cnt    = cyc_q;
    assign ret_cnt    = ret_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a vector table for the RUN-state
// hazard decode, then hand-written halt/drain/reset/saturation sequences.
module tb_pipe_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] id_instr;
    logic        ex_memread;
    logic [4:0]  ex_rd;
    logic        ex_halt;
    logic        branch_taken;
    logic [31:0] wb_instr;
    logic        wb_halt;

    logic        pc_stall, ifid_stall, ifid_flush, idex_flush;
    logic        halted, drain_err;
    logic [1:0]  state_o;
    logic [31:0] cyc_cnt, ret_cnt, stall_cnt, flush_cnt;

    logic        s_pc_stall, s_ifid_stall, s_ifid_flush, s_idex_flush;
    logic        s_halted, s_drain_err;
    logic [1:0]  s_state;
    logic [3:0]  s_cyc_cnt, s_ret_cnt, s_stall_cnt, s_flush_cnt;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [31:0] id_instr;
        logic        ex_memread;
        logic [4:0]  ex_rd;
        logic        branch_taken;
        logic [31:0] wb_instr;
        logic [3:0]  exp_ctrl;
    } vec_t;

    vec_t vecs[13];

    pipe_hazard_ctrl #(.CNT_W(32), .DRAIN_MAX(4)) dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_halt(ex_halt), .branch_taken(branch_taken),
        .wb_instr(wb_instr), .wb_halt(wb_halt),
        .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
        .idex_flush(idex_flush), .halted(halted), .drain_err(drain_err),
        .state(state_o), .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipe_hazard_ctrl #(.CNT_W(4), .DRAIN_MAX(4)) dut_small (
        .clk(clk), .reset(reset), .id_instr(id_instr), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .ex_halt(ex_halt), .branch_taken(branch_taken),
        .wb_instr(wb_instr), .wb_halt(wb_halt),
        .pc_stall(s_pc_stall), .ifid_stall(s_ifid_stall), .ifid_flush(s_ifid_flush),
        .idex_flush(s_idex_flush), .halted(s_halted), .drain_err(s_drain_err),
        .state(s_state), .cyc_cnt(s_cyc_cnt), .ret_cnt(s_ret_cnt),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        id_instr     = v.id_instr;
        ex_memread   = v.ex_memread;
        ex_rd        = v.ex_rd;
        branch_taken = v.branch_taken;
        wb_instr     = v.wb_instr;
        ex_halt      = 1'b0;
        wb_halt      = 1'b0;
    endtask

    task automatic clearInputs();
        id_instr     = 32'd0;
        ex_memread   = 1'b0;
        ex_rd        = 5'd0;
        ex_halt      = 1'b0;
        branch_taken = 1'b0;
        wb_instr     = 32'd0;
        wb_halt      = 1'b0;
    endtask

    task automatic doReset();
        clearInputs();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [31:0] ctrlWord();
        return {28'd0, pc_stall, ifid_stall, ifid_flush, idex_flush};
    endfunction

    initial begin
        // Expected ctrl nibble is {pc_stall, ifid_stall, ifid_flush, idex_flush}.
        vecs[0]  = '{32'h00228333, 1'b1, 5'd5, 1'b0, 32'h00000013, 4'b1101};
        vecs[1]  = '{32'h00228333, 1'b1, 5'd0, 1'b0, 32'h00000000, 4'b0000};
        vecs[2]  = '{32'h000283B7, 1'b1, 5'd5, 1'b0, 32'h00000000, 4'b0000};
        vecs[3]  = '{32'h00228333, 1'b1, 5'd2, 1'b0, 32'h00000000, 4'b1101};
        vecs[4]  = '{32'h00228313, 1'b1, 5'd2, 1'b0, 32'h00000000, 4'b0000};
        vecs[5]  = '{32'h00228333, 1'b0, 5'd5, 1'b0, 32'h00000000, 4'b0000};
        vecs[6]  = '{32'h00228333, 1'b1, 5'd5, 1'b1, 32'h00000000, 4'b0011};
        vecs[7]  = '{32'h00000013, 1'b0, 5'd0, 1'b1, 32'h00000000, 4'b0011};
        vecs[8]  = '{32'h0002806F, 1'b1, 5'd5, 1'b0, 32'h00000000, 4'b0000};
        vecs[9]  = '{32'h00228023, 1'b1, 5'd2, 1'b0, 32'h00000000, 4'b1101};
        vecs[10] = '{32'h00000013, 1'b0, 5'd0, 1'b0, 32'h00000013, 4'b0000};
        vecs[11] = '{32'h00228063, 1'b1, 5'd2, 1'b0, 32'h00000000, 4'b1101};
        vecs[12] = '{32'h00028317, 1'b1, 5'd5, 1'b0, 32'h00000000, 4'b0000};

        // Reset held low with a live load-use pattern: controls must stay 0.
        clearInputs();
        reset      = 1'b0;
        id_instr   = 32'h00228333;
        ex_memread = 1'b1;
        ex_rd      = 5'd5;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_ctrl", ctrlWord(), 32'd0);
        checkOutput("reset_state", {30'd0, state_o}, 32'd0);
        checkOutput("reset_cyc", cyc_cnt, 32'd0);
        checkOutput("reset_halted", {31'd0, halted}, 32'd0);
        checkOutput("reset_drain_err", {31'd0, drain_err}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Table: one vector per RUN cycle.
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_ctrl", i), ctrlWord(), {28'd0, vecs[i].exp_ctrl});
            @(posedge clk);
            #1;
        end
        clearInputs();
        @(negedge clk);
        checkOutput("table_cyc", cyc_cnt, 32'd13);
        checkOutput("table_ret", ret_cnt, 32'd2);
        checkOutput("table_stall", stall_cnt, 32'd4);
        checkOutput("table_flush", flush_cnt, 32'd2);
        checkOutput("table_state", {30'd0, state_o}, 32'd0);

        // Halt drained normally: wb_halt two cycles after ex_halt.
        doReset();
        ex_halt = 1'b1;
        @(negedge clk);
        checkOutput("halt_n_state", {30'd0, state_o}, 32'd0);
        checkOutput("halt_n_ctrl", ctrlWord(), 32'd0);
        @(posedge clk);
        #1;
        ex_halt      = 1'b0;
        branch_taken = 1'b1;
        @(negedge clk);
        checkOutput("halt_n1_state", {30'd0, state_o}, 32'd1);
        checkOutput("halt_n1_ctrl", ctrlWord(), 32'b1101);
        @(posedge clk);
        #1;
        branch_taken = 1'b0;
        wb_halt      = 1'b1;
        wb_instr     = 32'h00100073;
        @(negedge clk);
        checkOutput("halt_n2_state", {30'd0, state_o}, 32'd1);
        checkOutput("halt_n2_halted", {31'd0, halted}, 32'd0);
        @(posedge clk);
        #1;
        wb_halt  = 1'b0;
        wb_instr = 32'h00000013;
        @(negedge clk);
        checkOutput("halt_n3_state", {30'd0, state_o}, 32'd2);
        checkOutput("halt_n3_halted", {31'd0, halted}, 32'd1);
        checkOutput("halt_n3_drain_err", {31'd0, drain_err}, 32'd0);
        checkOutput("halt_n3_ctrl", ctrlWord(), 32'b1101);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("halted_cyc_frozen", cyc_cnt, 32'd3);
        checkOutput("halted_ret_frozen", ret_cnt, 32'd1);
        checkOutput("halted_flush_zero", flush_cnt, 32'd0);
        checkOutput("halted_state_hold", {30'd0, state_o}, 32'd2);

        // Halt that never reaches WB: timeout after four DRAIN cycles.
        doReset();
        ex_halt = 1'b1;
        @(posedge clk);
        #1;
        ex_halt = 1'b0;
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            checkOutput($sformatf("drain%0d_state", d), {30'd0, state_o}, 32'd1);
            checkOutput($sformatf("drain%0d_err", d), {31'd0, drain_err}, 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        checkOutput("timeout_state", {30'd0, state_o}, 32'd2);
        checkOutput("timeout_err", {31'd0, drain_err}, 32'd1);
        checkOutput("timeout_halted", {31'd0, halted}, 32'd1);
        checkOutput("timeout_cyc", cyc_cnt, 32'd5);

        // Reset pulse in the middle of DRAIN.
        doReset();
        wb_instr = 32'h00000013;
        ex_halt  = 1'b1;
        @(posedge clk);
        #1;
        ex_halt = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset_ctrl_forced", ctrlWord(), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_state", {30'd0, state_o}, 32'd0);
        checkOutput("midreset_cyc", cyc_cnt, 32'd0);
        checkOutput("midreset_ret", ret_cnt, 32'd0);
        checkOutput("midreset_ctrl", ctrlWord(), 32'd0);

        // Saturation: 20 retiring cycles into a 4-bit counter instance.
        doReset();
        wb_instr = 32'h00000013;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("sat_small_cyc", {28'd0, s_cyc_cnt}, 32'd15);
        checkOutput("sat_small_ret", {28'd0, s_ret_cnt}, 32'd15);
        checkOutput("sat_wide_cyc", cyc_cnt, 32'd20);
        checkOutput("sat_wide_ret", ret_cnt, 32'd20);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end

endmodule
